ps_clk_meter_sched: RTL and testbench
=====================================

Name: ps_clk_meter_sched

Overview:
Measures the four divided PS fabric clocks (the prescaled pl_clk_0..3 outputs) in the ila_clk domain. A round-robin scheduler selects one enabled channel at a time, synchronises it, and counts its rising edges over a fixed gate window. Per-channel results are held in registers for the ILA and software. Dead-clock flags show a PS clock that has stopped or was never enabled.

Parameters:
GATE_CYCLES, 1024, length of the measurement window in ila_clk cycles (>= 16)
SETTLE_CYCLES, 4, ila_clk cycles discarded after a channel switch (>= 3)
CNT_W, $clog2(GATE_CYCLES+1), width of each per-channel edge count
MIN_COUNT, 1, lower in-range limit (used only with the optional feature)
MAX_COUNT, GATE_CYCLES/2, upper in-range limit (used only with the optional feature)

Ports:
ila_clk  in  1  sole clock; all logic is in this domain
pl_resetn  in  1  asynchronous active-low reset
div_pl_clk_0..3  in  1 each  divided clocks, asynchronous to ila_clk, treated as data
enable  in  1  level; 1 = sweep continuously
chan_mask  in  4  bit i = measure channel i
count_0..3  out  CNT_W each  last completed edge count per channel
count_valid  out  4  bit i = count_i holds at least one completed result
dead  out  4  bit i = last count_i was 0
out_of_range  out  4  range-check flags (optional feature)
busy  out  1  FSM not in IDLE
cur_chan  out  2  channel currently selected
sweep_done  out  1  one-cycle pulse when the last enabled channel of a sweep is stored

Behaviour:
- Reset (async assert, sync release): all counts 0, count_valid/dead/out_of_range 0, busy 0, cur_chan 0, sweep_done 0, FSM in IDLE.
- Each input passes through a 2-flop synchroniser, always running. The mux after the synchronisers selects cur_chan. An edge detector compares the mux output with a registered copy.
- FSM states: IDLE, SELECT, SETTLE, GATE, STORE.
  - IDLE: leave when enable=1 and chan_mask != 0. Go to SELECT, starting the search from bit 0.
  - SELECT (1 cycle): cur_chan <= lowest set mask bit at or after the search start, wrapping 3->0. The mask is sampled here only, so mask changes take effect at the next SELECT. If the mask is now 0, go to IDLE.
  - SETTLE: hold for SETTLE_CYCLES. On the last cycle, preload the edge-detect register with the current mux output so no false edge is counted.
  - GATE: run exactly GATE_CYCLES cycles. Each cycle with a detected rising edge increments the working counter, which saturates at 2^CNT_W-1.
  - STORE (1 cycle): count_cur_chan <= working count. count_valid[cur_chan] <= 1. dead[cur_chan] <= (count == 0). The working counter clears.
    - If cur_chan is the highest set mask bit, pulse sweep_done.
    - If enable=1, go to SELECT, searching from cur_chan+1 mod 4. If enable=0, go to IDLE.
- enable falling mid-window: the current window completes and is stored, then the FSM goes to IDLE. The window is never truncated.
- Latency per channel: 1 + SETTLE_CYCLES + GATE_CYCLES + 1 cycles.
- Stored counts of unmasked channels keep their old values. Their count_valid bits are not cleared.
- busy = (state != IDLE).

Optional Feature:
PS_CLK_METER_RANGE_EN
- Defined: in STORE, out_of_range[cur_chan] <= (count < MIN_COUNT) or (count > MAX_COUNT). Updates in the same cycle as count.
- Undefined: out_of_range tied to 0, no comparators. Port list unchanged.

Decomposition:
- Package ps_inspect_pkg: NUM_CLK = 4; FSM state enum (IDLE, SELECT, SETTLE, GATE, STORE); function next_chan(mask, start) returning the wrapped lowest-set-bit index.
- One sub-module, sync_rise_detect: 2-flop synchroniser plus rising-edge detect. Instantiated 4 times for synchronisation only; the edge detect runs on the mux output.

Test Plan:
- GATE_CYCLES=1024, mask=4'b1111, div_pl_clk_i period = 16/32/64/128 ila_clk → counts 64/32/16/8 (±1); count_valid=4'b1111; sweep_done pulses once after channel 3; dead=0.
- Channel 2 held at 0, mask=4'b0100 → count_2=0, dead[2]=1. Then restart clock 2 at period 16 → next window count_2=64 (±1), dead[2]=0.
- mask=4'b1010, enable held high → cur_chan sequence 1,3,1,3; channels 0 and 2 never selected; count_0 and count_2 stay 0 with valid bits 0.
- enable dropped 100 cycles into GATE on channel 0 → busy stays 1 for the rest of the window, count_0 stored, then IDLE with busy=0. mask=0 with enable=1 → FSM remains IDLE.
- pl_resetn asserted mid-GATE → all outputs return to reset values asynchronously. After release, first result appears only after a full SELECT+SETTLE+GATE+STORE sequence.
- With PS_CLK_METER_RANGE_EN, MIN_COUNT=20, MAX_COUNT=40, period 16 → out_of_range=1; period 32 → 0. Without the macro → out_of_range stays 0.

Source files
------------

// File: rtl/ps_inspect_pkg.sv
// Shared definitions for the PS clock meter: channel count, FSM states and
// the round-robin channel search helpers.
package ps_inspect_pkg;

   localparam int NUM_CLK = 4;
   localparam int CHAN_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_GATE   = 3'd3,
      ST_STORE  = 3'd4
   } state_e;

   // Lowest set mask bit at or after start, wrapping 3 -> 0.
   function automatic logic [CHAN_W-1:0] next_chan(input logic [NUM_CLK-1:0] mask,
                                                   input logic [CHAN_W-1:0]  start);
      logic [CHAN_W-1:0] idx;
      logic              found;
      next_chan = start;
      found     = 1'b0;
      for (int i = 0; i < NUM_CLK; i++) begin
         idx = start + CHAN_W'(i);
         if (!found && mask[idx]) begin
            next_chan = idx;
            found     = 1'b1;
         end
      end
   endfunction

   function automatic logic [CHAN_W-1:0] high_chan(input logic [NUM_CLK-1:0] mask);
      high_chan = '0;
      for (int i = 0; i < NUM_CLK; i++) begin
         if (mask[i]) high_chan = CHAN_W'(i);
      end
   endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous level, with a rising-edge detect
// on the synchronised output.
module sync_rise_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic [1:0] r_sync;
   logic       r_prev;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbour and the chain shifts cleanly.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_async};
         r_prev <= r_sync[1];
      end
   end

   assign o_sync = r_sync[1];
   assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/ps_clk_meter_sched.sv
// Round-robin frequency meter for the four divided PS clocks, in the ila_clk domain.
// Optional range check: define PS_CLK_METER_RANGE_EN to build the out_of_range comparators.
module ps_clk_meter_sched
   import ps_inspect_pkg::*;
#(
   parameter int GATE_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(GATE_CYCLES + 1),
   parameter int MIN_COUNT     = 1,
   parameter int MAX_COUNT     = GATE_CYCLES / 2
) (
   input  logic               ila_clk,
   input  logic               pl_resetn,
   input  logic               div_pl_clk_0,
   input  logic               div_pl_clk_1,
   input  logic               div_pl_clk_2,
   input  logic               div_pl_clk_3,
   input  logic               enable,
   input  logic [NUM_CLK-1:0] chan_mask,
   output logic [CNT_W-1:0]   count_0,
   output logic [CNT_W-1:0]   count_1,
   output logic [CNT_W-1:0]   count_2,
   output logic [CNT_W-1:0]   count_3,
   output logic [NUM_CLK-1:0] count_valid,
   output logic [NUM_CLK-1:0] dead,
   output logic [NUM_CLK-1:0] out_of_range,
   output logic               busy,
   output logic [CHAN_W-1:0]  cur_chan,
   output logic               sweep_done
);

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX);

   logic [NUM_CLK-1:0] w_div;
   logic [NUM_CLK-1:0] w_sync;
   logic [NUM_CLK-1:0] w_rise_unused;
   logic               w_mux;
   logic               w_rise;

   state_e             r_state;
   logic [CHAN_W-1:0]  r_cur_chan;
   logic [CHAN_W-1:0]  r_search;
   logic [NUM_CLK-1:0] r_mask;
   logic [TMR_W-1:0]   r_timer;
   logic [CNT_W-1:0]   r_work;
   logic               r_mux_q;
   logic               r_sweep_done;

   logic [CNT_W-1:0]   r_count [NUM_CLK];
   logic [NUM_CLK-1:0] r_valid;
   logic [NUM_CLK-1:0] r_dead;

   assign w_div = {div_pl_clk_3, div_pl_clk_2, div_pl_clk_1, div_pl_clk_0};

   for (genvar g = 0; g < NUM_CLK; g++) begin : g_sync
      sync_rise_detect u_sync (
         .i_clk   (ila_clk),
         .i_rst_n (pl_resetn),
         .i_async (w_div[g]),
         .o_sync  (w_sync[g]),
         .o_rise  (w_rise_unused[g])
      );
   end

   // Edge detect after the mux; r_mux_q tracks the mux every cycle, which also
   // covers the preload on the last SETTLE cycle so a switch never counts an edge.
   assign w_mux  = w_sync[r_cur_chan];
   assign w_rise = w_mux & ~r_mux_q;

   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         r_state      <= ST_IDLE;
         r_cur_chan   <= '0;
         r_search     <= '0;
         r_mask       <= '0;
         r_timer      <= '0;
         r_work       <= '0;
         r_mux_q      <= 1'b0;
         r_sweep_done <= 1'b0;
      end else begin
         r_sweep_done <= 1'b0;
         r_mux_q      <= w_mux;
         case (r_state)
            ST_IDLE: begin
               if (enable && (chan_mask != '0)) begin
                  r_search <= '0;
                  r_state  <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               r_mask <= chan_mask;
               if (chan_mask == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cur_chan <= next_chan(chan_mask, r_search);
                  r_timer    <= TMR_W'(SETTLE_CYCLES - 1);
                  r_state    <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_timer == '0) begin
                  r_timer <= TMR_W'(GATE_CYCLES - 1);
                  r_state <= ST_GATE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            ST_GATE: begin
               if (w_rise && (r_work != '1)) r_work <= r_work + 1'b1;
               if (r_timer == '0) r_state <= ST_STORE;
               else               r_timer <= r_timer - 1'b1;
            end
            ST_STORE: begin
               r_work       <= '0;
               r_sweep_done <= (r_cur_chan == high_chan(r_mask));
               if (enable) begin
                  r_search <= r_cur_chan + 1'b1;
                  r_state  <= ST_SELECT;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the result bank is reset element by element because software reads
   // it directly and must see zeros after reset, not power-up garbage.
   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         for (int i = 0; i < NUM_CLK; i++) r_count[i] <= '0;
         r_valid <= '0;
         r_dead  <= '0;
      end else if (r_state == ST_STORE) begin
         r_count[r_cur_chan] <= r_work;
         r_valid[r_cur_chan] <= 1'b1;
         r_dead[r_cur_chan]  <= (r_work == '0);
      end
   end

`ifdef PS_CLK_METER_RANGE_EN
   logic [NUM_CLK-1:0] r_oor;

   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         r_oor <= '0;
      end else if (r_state == ST_STORE) begin
         r_oor[r_cur_chan] <= (int'(r_work) < MIN_COUNT) || (int'(r_work) > MAX_COUNT);
      end
   end

   assign out_of_range = r_oor;
`else
   // Limits only matter when the range comparators are built in.
   localparam int RANGE_LIMITS_UNUSED = MIN_COUNT + MAX_COUNT;

   assign out_of_range = '0;
`endif

   assign count_0     = r_count[0];
   assign count_1     = r_count[1];
   assign count_2     = r_count[2];
   assign count_3     = r_count[3];
   assign count_valid = r_valid;
   assign dead        = r_dead;
   assign busy        = (r_state != ST_IDLE);
   assign cur_chan    = r_cur_chan;
   assign sweep_done  = r_sweep_done;

endmodule

// File: tb/tb_ps_clk_meter_sched.sv
// Self-checking bench for ps_clk_meter_sched: randomised clock periods against
// an edges-per-window model, plus scheduling, dead-clock, enable and reset scenarios.
`timescale 1ns/1ps
module tb_ps_clk_meter_sched;

   localparam int G    = 1024;
   localparam int S    = 4;
   localparam int CW   = $clog2(G + 1);
   localparam int MINC = 20;
   localparam int MAXC = 40;
   localparam int L    = 1 + S + G + 1;

   logic          ila_clk = 1'b0;
   logic          pl_resetn;
   logic          enable;
   logic [3:0]    chan_mask;
   logic [3:0]    div;
   logic [CW-1:0] count_0, count_1, count_2, count_3;
   logic [3:0]    count_valid, dead, out_of_range;
   logic          busy;
   logic [1:0]    cur_chan;
   logic          sweep_done;

   int per [4] = '{0, 0, 0, 0};
   int errors  = 0;
   int checks  = 0;

   always #5 ila_clk = ~ila_clk;

   // Divided clocks: half-period of per[g]*5 ns, held low while per[g] is 0.
   for (genvar g = 0; g < 4; g++) begin : g_div
      logic clk_q;
      initial begin
         clk_q = 1'b0;
         #(2 + g);
         forever begin
            if (per[g] == 0) begin
               clk_q = 1'b0;
               #10;
            end else begin
               #(per[g] * 5);
               clk_q = ~clk_q;
            end
         end
      end
      assign div[g] = clk_q;
   end

   ps_clk_meter_sched #(
      .GATE_CYCLES   (G),
      .SETTLE_CYCLES (S),
      .MIN_COUNT     (MINC),
      .MAX_COUNT     (MAXC)
   ) dut (
      .ila_clk      (ila_clk),
      .pl_resetn    (pl_resetn),
      .div_pl_clk_0 (div[0]),
      .div_pl_clk_1 (div[1]),
      .div_pl_clk_2 (div[2]),
      .div_pl_clk_3 (div[3]),
      .enable       (enable),
      .chan_mask    (chan_mask),
      .count_0      (count_0),
      .count_1      (count_1),
      .count_2      (count_2),
      .count_3      (count_3),
      .count_valid  (count_valid),
      .dead         (dead),
      .out_of_range (out_of_range),
      .busy         (busy),
      .cur_chan     (cur_chan),
      .sweep_done   (sweep_done)
   );

   function automatic int get_count(input int i);
      case (i)
         0:       return int'(count_0);
         1:       return int'(count_1);
         2:       return int'(count_2);
         default: return int'(count_3);
      endcase
   endfunction

   // Rising edges in a G-cycle window of a period-p clock, allowing +-1.
   function automatic int cnt_lo(input int p);
      if (p == 0) return 0;
      return G / p - 1;
   endfunction

   function automatic int cnt_hi(input int p);
      if (p == 0) return 0;
      return (G + p - 1) / p + 1;
   endfunction

   // Expected range flag; known=0 when the +-1 band straddles a limit.
   function automatic bit oor_model(input int p, output bit known);
`ifdef PS_CLK_METER_RANGE_EN
      int lo, hi;
      lo = cnt_lo(p);
      hi = cnt_hi(p);
      if (p == 0) lo = 0;
      if (hi < MINC || lo > MAXC) begin known = 1'b1; return 1'b1; end
      if (lo >= MINC && hi <= MAXC) begin known = 1'b1; return 1'b0; end
      known = 1'b0;
      return 1'b0;
`else
      known = (p >= 0);
      return 1'b0;
`endif
   endfunction

   // Holds reset long enough for any pending divided-clock half-period to expire.
   task automatic apply_reset();
      enable    = 1'b0;
      chan_mask = 4'b0000;
      pl_resetn = 1'b0;
      repeat (150) @(negedge ila_clk);
      #2 pl_resetn = 1'b1;
   endtask

   task automatic drain();
      int n;
      enable = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < L + 10) begin
         @(negedge ila_clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_idle: busy=%b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (cur_chan !== 2'd0) begin errors++; $display("FAIL reset_cur_chan: got %0d want 0", cur_chan); end
      checks++;
      if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b want 0", sweep_done); end
      checks++;
      if (count_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", count_valid); end
      checks++;
      if (dead !== 4'b0000) begin errors++; $display("FAIL reset_dead: got %b want 0000", dead); end
      checks++;
      if (out_of_range !== 4'b0000) begin errors++; $display("FAIL reset_oor: got %b want 0000", out_of_range); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_count(i) !== 0) begin
            errors++;
            $display("FAIL reset_count[%0d]: got %0d want 0", i, get_count(i));
         end
      end
      chan_mask = 4'b1111;
      repeat (20) @(negedge ila_clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_enable: busy=%b want 0", busy); end
   endtask

   task automatic test_random_sweep();
      for (int it = 0; it < 4; it++) begin
         logic [3:0] m;
         int         n, c;
         bit         known, exp_oor;
         if (it == 0) begin
            m   = 4'b1111;
            per = '{16, 32, 64, 128};
         end else begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++)
               per[i] = ($urandom_range(0, 4) == 0) ? 0 : 2 * int'($urandom_range(4, 64));
         end
         apply_reset();
         chan_mask = m;
         enable    = 1'b1;
         n = 0;
         while (sweep_done !== 1'b1 && n < 5 * L) begin
            @(negedge ila_clk);
            n++;
         end
         checks++;
         if (sweep_done !== 1'b1) begin
            errors++;
            $display("FAIL sweep_done_seen[%0d]: no pulse in %0d cycles, mask=%b", it, n, m);
         end
         checks++;
         if (count_valid !== m) begin
            errors++;
            $display("FAIL sweep_valid[%0d]: got %b want %b", it, count_valid, m);
         end
         for (int i = 0; i < 4; i++) begin
            c = get_count(i);
            if (m[i]) begin
               checks++;
               if (c < cnt_lo(per[i]) || c > cnt_hi(per[i])) begin
                  errors++;
                  $display("FAIL sweep_count[%0d][%0d]: got %0d want %0d..%0d (period %0d)",
                           it, i, c, cnt_lo(per[i]), cnt_hi(per[i]), per[i]);
               end
               checks++;
               if (dead[i] !== (per[i] == 0)) begin
                  errors++;
                  $display("FAIL sweep_dead[%0d][%0d]: got %b want %b", it, i, dead[i], per[i] == 0);
               end
               exp_oor = oor_model(per[i], known);
               if (known) begin
                  checks++;
                  if (out_of_range[i] !== exp_oor) begin
                     errors++;
                     $display("FAIL sweep_oor[%0d][%0d]: got %b want %b", it, i, out_of_range[i], exp_oor);
                  end
               end
            end else begin
               checks++;
               if (c !== 0 || out_of_range[i] !== 1'b0) begin
                  errors++;
                  $display("FAIL sweep_unmasked[%0d][%0d]: count=%0d oor=%b want 0/0", it, i, c, out_of_range[i]);
               end
            end
         end
         @(negedge ila_clk);
         checks++;
         if (sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_pulse_width[%0d]: got %b want 0", it, sweep_done);
         end
         drain();
      end
   endtask

   task automatic test_dead_restart();
      int n;
      per = '{32, 32, 0, 32};
      apply_reset();
      chan_mask = 4'b0100;
      enable    = 1'b1;
      n = 0;
      while (count_valid[2] !== 1'b1 && n < 2 * L) begin
         @(negedge ila_clk);
         n++;
      end
      checks++;
      if (count_valid !== 4'b0100) begin errors++; $display("FAIL dead_valid: got %b want 0100", count_valid); end
      checks++;
      if (count_2 !== '0) begin errors++; $display("FAIL dead_count: got %0d want 0", count_2); end
      checks++;
      if (dead !== 4'b0100) begin errors++; $display("FAIL dead_flag: got %b want 0100", dead); end
      per[2] = 16;
      repeat (L - 1) @(negedge ila_clk);
      checks++;
      if (dead[2] !== 1'b1) begin errors++; $display("FAIL dead_latency: dead[2]=%b before %0d cycles, want 1", dead[2], L); end
      @(negedge ila_clk);
      checks++;
      if (dead[2] !== 1'b0) begin errors++; $display("FAIL restart_dead: got %b want 0", dead[2]); end
      repeat (L) @(negedge ila_clk);
      checks++;
      if (int'(count_2) < cnt_lo(16) || int'(count_2) > cnt_hi(16)) begin
         errors++;
         $display("FAIL restart_count: got %0d want %0d..%0d", count_2, cnt_lo(16), cnt_hi(16));
      end
      drain();
   endtask

   task automatic test_alternate_mask();
      int         seq[$];
      int         exp_seq[4] = '{1, 3, 1, 3};
      logic [1:0] prev;
      int         n;
      for (int i = 0; i < 4; i++) per[i] = 2 * int'($urandom_range(4, 64));
      apply_reset();
      chan_mask = 4'b1010;
      enable    = 1'b1;
      prev = cur_chan;
      n = 0;
      while (seq.size() < 4 && n < 5 * L) begin
         @(negedge ila_clk);
         n++;
         if (cur_chan !== prev) begin
            seq.push_back(int'(cur_chan));
            prev = cur_chan;
         end
      end
      checks++;
      if (seq.size() != 4) begin
         errors++;
         $display("FAIL alt_seq_len: got %0d channel switches want 4", seq.size());
      end
      for (int k = 0; k < 4 && k < seq.size(); k++) begin
         checks++;
         if (seq[k] != exp_seq[k]) begin
            errors++;
            $display("FAIL alt_seq[%0d]: got %0d want %0d", k, seq[k], exp_seq[k]);
         end
      end
      checks++;
      if (count_valid !== 4'b1010) begin errors++; $display("FAIL alt_valid: got %b want 1010", count_valid); end
      checks++;
      if (count_0 !== '0 || count_2 !== '0) begin
         errors++;
         $display("FAIL alt_unselected: count_0=%0d count_2=%0d want 0/0", count_0, count_2);
      end
      drain();
   endtask

   task automatic test_enable_drop();
      int bad;
      per[0] = 2 * int'($urandom_range(4, 64));
      apply_reset();
      chan_mask = 4'b0001;
      enable    = 1'b1;
      repeat (2 + S + 100) @(negedge ila_clk);
      enable = 1'b0;
      bad = 0;
      for (int k = 2 + S + 101; k <= 2 + S + G; k++) begin
         @(negedge ila_clk);
         if (busy !== 1'b1 || count_valid[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL enable_drop_hold: %0d cycles idle or stored early, want 0", bad);
      end
      @(negedge ila_clk);
      checks++;
      if (busy !== 1'b0 || count_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL enable_drop_store: busy=%b valid0=%b want 0/1", busy, count_valid[0]);
      end
      checks++;
      if (int'(count_0) < cnt_lo(per[0]) || int'(count_0) > cnt_hi(per[0])) begin
         errors++;
         $display("FAIL enable_drop_count: got %0d want %0d..%0d", count_0, cnt_lo(per[0]), cnt_hi(per[0]));
      end
      chan_mask = 4'b0000;
      enable    = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge ila_clk);
         if (busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL zero_mask_idle: busy for %0d cycles want 0", bad);
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_gate();
      int n;
      per[0] = 32;
      apply_reset();
      chan_mask = 4'b0001;
      enable    = 1'b1;
      n = 0;
      while (count_valid[0] !== 1'b1 && n < 2 * L) begin
         @(negedge ila_clk);
         n++;
      end
      checks++;
      if (count_valid[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_result: valid0=%b want 1", count_valid[0]); end
      repeat (300) @(negedge ila_clk);
      #2 pl_resetn = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || count_valid !== 4'b0000 || dead !== 4'b0000 || cur_chan !== 2'd0) begin
         errors++;
         $display("FAIL rst_async_flags: busy=%b valid=%b dead=%b chan=%0d want 0", busy, count_valid, dead, cur_chan);
      end
      checks++;
      if (count_0 !== '0 || out_of_range !== 4'b0000 || sweep_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_async_count: count_0=%0d oor=%b sweep=%b want 0", count_0, out_of_range, sweep_done);
      end
      repeat (3) @(negedge ila_clk);
      #2 pl_resetn = 1'b1;
      n = 0;
      while (count_valid[0] !== 1'b1 && n < L + 10) begin
         @(negedge ila_clk);
         n++;
      end
      checks++;
      if (n != L + 1) begin
         errors++;
         $display("FAIL rst_first_result: after %0d cycles want %0d", n, L + 1);
      end
      checks++;
      if (int'(count_0) < cnt_lo(32) || int'(count_0) > cnt_hi(32)) begin
         errors++;
         $display("FAIL rst_first_count: got %0d want %0d..%0d", count_0, cnt_lo(32), cnt_hi(32));
      end
      drain();
   endtask

   initial begin
      pl_resetn = 1'b0;
      enable    = 1'b0;
      chan_mask = 4'b0000;
      test_reset();
      test_random_sweep();
      test_dead_restart();
      test_alternate_mask();
      test_enable_drop();
      test_reset_mid_gate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
